reg_write_port: RTL and testbench
=================================

// Module: reg_write_port
// PURPOSE
//  Write end of the pipeline register file: owns 31x32 storage ($1-$31), arbitrates the WB-stage
//  writer against the exception writer ($k0 <- EPC), buffers blocked WB writes in a small FIFO.
//  Provides the two combinational read ports consumed by ID; $0 is hard-wired zero.
// PARAMETERS
//  DATA_W      32  register width
//  ADDR_W      5   register index width
//  FIFO_DEPTH  2   WB write buffer entries (>=1)
//  EXC_REG     26  register written by the exception port
// PORTS
//  clk            in   1       clock, rising edge
//  reset          in   1       synchronous, active-high
//  wb_valid       in   1       WB write request
//  wb_ready       out  1       request accepted when wb_valid&&wb_ready at clk edge
//  wb_addr        in   ADDR_W  destination register
//  wb_data        in   DATA_W  write data
//  exc_valid      in   1       exception write, always accepted, no ready
//  exc_data       in   DATA_W  value for EXC_REG
//  read_register1 in   ADDR_W  read port 1 index
//  read_register2 in   ADDR_W  read port 2 index
//  read_data1     out  DATA_W  read port 1 data
//  read_data2     out  DATA_W  read port 2 data
//  rd_pending1    out  1       port 1 index has a queued, uncommitted write
//  rd_pending2    out  1       port 2 index has a queued, uncommitted write
//  commit_valid   out  1       storage written this cycle
//  commit_addr    out  ADDR_W  register written this cycle
// BEHAVIOUR
//  - Reset: all storage 0, FIFO empty; wb_ready=0, commit_valid=0, commit_addr=0, rd_pending*=0
//    while reset high; wb_ready=1 the cycle after reset deasserts. Reset mid-burst drops queued writes.
//  - wb_ready = !reset && (count != FIFO_DEPTH); registered count only, no same-cycle dequeue credit.
//  - One storage write per cycle, priority: exc > FIFO head > accepted WB (cut-through, FIFO empty only).
//  - Accepted WB while exc_valid or FIFO non-empty -> enqueued at tail; program order preserved.
//  - Simultaneous dequeue+enqueue: count unchanged; head commits, new entry at tail.
//  - wb_addr==0: handshake completes, nothing enqueued or written, commit_valid=0.
//  - exc_valid squashes every queued entry with addr==EXC_REG (exception is youngest write).
//  - Storage write takes effect at clk edge; latency accept->storage: 0 (cut-through) to count+exc cycles.
//  - Read index 0 -> 0 unconditionally. rd_pendingN = any valid FIFO entry matches index (index!=0).
//  - commit_valid/commit_addr are combinational from this cycle's selected write.
// CONFIGURATION
//  REG_BYPASS_EN defined: read_dataN forwards, priority exc write (index==EXC_REG) > accepted WB
//    this cycle > youngest matching FIFO entry > storage; rd_pendingN still reported for stats.
//  REG_BYPASS_EN undefined: read_dataN = storage only; value visible cycle after commit; ID must
//    stall on rd_pendingN or on commit_addr match.
// STRUCTURE
//  rf_pkg: DATA_W/ADDR_W defaults, REG_ZERO=0, EXC_REG_DEFAULT=26, typedef wb_entry_t {valid,addr,data}.
//  Sub-module rf_write_fifo: FIFO_DEPTH entries of wb_entry_t, head/tail/count, per-entry squash by
//  address, youngest-match lookup for two indices. Top holds storage, arbiter, read muxes.
// TESTING
//  1. reset, then wb {addr=5,data=0xDEADBEEF} -> commit_valid=1,commit_addr=5; next cycle read_data1(5)=0xDEADBEEF.
//  2. wb {3,0x11} with exc_valid,exc_data=0x400 same cycle -> commit 26 now, 3 enqueued, rd_pending(3)=1, commits next cycle.
//  3. exc held 3 cycles with wb every cycle -> wb_ready drops to 0 after 2 accepts; queue drains in order once exc drops.
//  4. queue {26,0x1} then exc_valid {0x2} -> entry squashed; reg26=0x2 permanently, never 0x1.
//  5. wb {0,0xFFFFFFFF} -> accepted, commit_valid=0, read_data(0)=0.
//  6. REG_BYPASS_EN: wb {7,0xA5} cut-through, read_register1=7 same cycle -> read_data1=0xA5; without macro -> old value.

Source files
------------

// File: rtl/rf_pkg.sv
// Register-file write-port package: widths, fixed register indices, WB buffer entry type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rf_pkg;

  localparam int RF_DATA_W          = 32;
  localparam int RF_ADDR_W          = 5;
  localparam int REG_ZERO           = 0;
  localparam int EXC_REG_DEFAULT    = 26;
  localparam int FIFO_DEPTH_DEFAULT = 2;

  // One buffered WB write. valid drops when the entry is popped or squashed.
  typedef struct packed {
    logic                 valid;
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic is_zero_reg(input logic [RF_ADDR_W-1:0] a);
    return a == RF_ADDR_W'(REG_ZERO);
  endfunction

endpackage

// File: rtl/reg_write_port_if.sv
// Bus bundle between the pipeline (master) and the register-file write port (slave).
// Latency: n/a (wires only).
// Backpressure: wb_valid/wb_ready handshake; exception and read ports have none.
// Signals: WB request (wb_valid/wb_ready/wb_addr/wb_data), exception write (exc_valid/exc_data),
//   two read ports (read_registerN -> read_dataN, rd_pendingN), commit strobe (commit_valid/addr).
interface reg_write_port_if #(
  parameter int DATA_W = rf_pkg::RF_DATA_W,
  parameter int ADDR_W = rf_pkg::RF_ADDR_W
);

  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              exc_valid;
  logic [DATA_W-1:0] exc_data;
  logic [ADDR_W-1:0] read_register1;
  logic [ADDR_W-1:0] read_register2;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic              rd_pending1;
  logic              rd_pending2;
  logic              commit_valid;
  logic [ADDR_W-1:0] commit_addr;

  modport master (
    output wb_valid, wb_addr, wb_data, exc_valid, exc_data, read_register1, read_register2,
    input  wb_ready, read_data1, read_data2, rd_pending1, rd_pending2, commit_valid, commit_addr
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data, exc_valid, exc_data, read_register1, read_register2,
    output wb_ready, read_data1, read_data2, rd_pending1, rd_pending2, commit_valid, commit_addr
  );

endinterface

// File: rtl/rf_write_fifo.sv
// Ring buffer of pending WB writes with per-entry squash by address and two youngest-match lookups.
// Latency: enqueue visible at head/lookup the cycle after enq_vld; lookups are combinational.
// Backpressure: none internally; the caller must not enqueue when count==DEPTH or pop when empty.
// Ports: clk/reset; enq_vld/enq_dat (tail write); pop (retire head); squash_vld/squash_addr
//   (invalidate every matching entry); head_dat/count; lk_addrN -> lk_hitN/lk_datN.
module rf_write_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enq_vld,
  input  wb_entry_t                    enq_dat,
  input  logic                         pop,
  input  logic                         squash_vld,
  input  logic [RF_ADDR_W-1:0]         squash_addr,
  output wb_entry_t                    head_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  input  logic [RF_ADDR_W-1:0]         lk_addr1,
  input  logic [RF_ADDR_W-1:0]         lk_addr2,
  output logic                         lk_hit1,
  output logic [RF_DATA_W-1:0]         lk_dat1,
  output logic                         lk_hit2,
  output logic [RF_DATA_W-1:0]         lk_dat2
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  wb_entry_t        ent_q [DEPTH];
  wb_entry_t        ent_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] slot;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == DEPTH-1) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= DEPTH) s = s - DEPTH;
    return PTR_W'(s);
  endfunction

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    // Squashed entries keep their slot until they reach the head and are popped silently.
    if (squash_vld) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (ent_q[j].addr == squash_addr) ent_d[j].valid = 1'b0;
      end
    end

    if (pop) begin
      ent_d[head_q].valid = 1'b0;
      head_d              = ptr_inc(head_q);
    end

    if (enq_vld) begin
      ent_d[tail_q]       = enq_dat;
      ent_d[tail_q].valid = 1'b1;
      tail_d              = ptr_inc(tail_q);
    end

    count_d = count_q + CNT_W'(enq_vld) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < DEPTH; j++) ent_q[j] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Walk oldest to youngest so the last match wins: forwarding must see the newest value.
  always_comb begin
    lk_hit1 = 1'b0;
    lk_dat1 = '0;
    lk_hit2 = 1'b0;
    lk_dat2 = '0;
    slot    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < int'(count_q)) begin
        slot = ptr_add(head_q, i);
        if (ent_q[slot].valid && ent_q[slot].addr == lk_addr1) begin
          lk_hit1 = 1'b1;
          lk_dat1 = ent_q[slot].data;
        end
        if (ent_q[slot].valid && ent_q[slot].addr == lk_addr2) begin
          lk_hit2 = 1'b1;
          lk_dat2 = ent_q[slot].data;
        end
      end
    end
  end

  assign head_dat = ent_q[head_q];
  assign count    = count_q;

endmodule

// File: rtl/reg_write_port.sv
// Write end of the register file: 31 storage words, exc > FIFO head > cut-through WB arbiter,
//   WB overflow buffer, two combinational read ports ($0 reads zero).
// Latency: accept->storage 0 cycles (cut-through) up to count+exception cycles; reads combinational.
// Backpressure: wb_ready = !reset && buffer not full (registered count only); exception never stalls.
// Ports: clk, reset (synchronous, active-high), bus (reg_write_port_if.slave).
// Build option: REG_BYPASS_EN forwards exc/WB/buffered data onto the read ports; without it the
//   read ports show storage only and the consumer stalls on rd_pendingN or commit_addr.
// DATA_W/ADDR_W must match the rf_pkg widths, which size the buffered entry type.
module reg_write_port #(
  parameter int DATA_W     = rf_pkg::RF_DATA_W,
  parameter int ADDR_W     = rf_pkg::RF_ADDR_W,
  parameter int FIFO_DEPTH = rf_pkg::FIFO_DEPTH_DEFAULT,
  parameter int EXC_REG    = rf_pkg::EXC_REG_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  reg_write_port_if.slave bus
);

  import rf_pkg::*;

  localparam int                NREGS = 1 << ADDR_W;
  localparam int                CNT_W = $clog2(FIFO_DEPTH+1);
  localparam logic [ADDR_W-1:0] EXC_A = ADDR_W'(EXC_REG);

  logic [DATA_W-1:0] regs_q [1:NREGS-1];
  logic [DATA_W-1:0] regs_d [1:NREGS-1];

  wb_entry_t         head;
  wb_entry_t         enq_dat;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              lk_hit1, lk_hit2;
  logic [DATA_W-1:0] lk_dat1, lk_dat2;

  logic              exc_live;
  logic              wb_rdy;
  logic              wb_live;
  logic              cut_through;
  logic              enq_vld;
  logic              pop;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  rf_write_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .enq_vld     (enq_vld),
    .enq_dat     (enq_dat),
    .pop         (pop),
    .squash_vld  (exc_live),
    .squash_addr (EXC_A),
    .head_dat    (head),
    .count       (fifo_count),
    .lk_addr1    (bus.read_register1),
    .lk_addr2    (bus.read_register2),
    .lk_hit1     (lk_hit1),
    .lk_dat1     (lk_dat1),
    .lk_hit2     (lk_hit2),
    .lk_dat2     (lk_dat2)
  );

  // Request decode and write arbitration.
  always_comb begin
    fifo_empty  = (fifo_count == '0);
    exc_live    = bus.exc_valid && !reset;
    wb_rdy      = !reset && (int'(fifo_count) != FIFO_DEPTH);
    // Writes to $0 complete the handshake but go nowhere.
    wb_live     = bus.wb_valid && wb_rdy && !is_zero_reg(bus.wb_addr);
    cut_through = wb_live && !exc_live && fifo_empty;
    // A WB to EXC_REG in the same cycle as the exception is older than it, so it is dropped.
    enq_vld     = wb_live && (exc_live || !fifo_empty) && !(exc_live && bus.wb_addr == EXC_A);
    // A squashed head needs no write slot, so it can retire even while the exception owns the port.
    pop         = !reset && !fifo_empty &&
                  (!exc_live || !head.valid || head.addr == EXC_A);

    enq_dat       = '0;
    enq_dat.valid = 1'b1;
    enq_dat.addr  = bus.wb_addr;
    enq_dat.data  = bus.wb_data;

    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (exc_live) begin
      wr_en   = 1'b1;
      wr_addr = EXC_A;
      wr_data = bus.exc_data;
    end else if (!reset && !fifo_empty && head.valid) begin
      wr_en   = 1'b1;
      wr_addr = head.addr;
      wr_data = head.data;
    end else if (cut_through) begin
      wr_en   = 1'b1;
      wr_addr = bus.wb_addr;
      wr_data = bus.wb_data;
    end
  end

  always_comb begin
    regs_d = regs_q;
    for (int r = 1; r < NREGS; r++) begin
      if (wr_en && int'(wr_addr) == r) regs_d[r] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 1; r < NREGS; r++) regs_q[r] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  function automatic logic [DATA_W-1:0] storage_rd(input logic [ADDR_W-1:0] a);
    return is_zero_reg(a) ? '0 : regs_q[a];
  endfunction

`ifdef REG_BYPASS_EN
  // Youngest value wins: exception, then this cycle's accepted WB, then the buffer, then storage.
  function automatic logic [DATA_W-1:0] read_sel(input logic [ADDR_W-1:0] a,
                                                 input logic pend,
                                                 input logic [DATA_W-1:0] fdat);
    logic [DATA_W-1:0] v;
    if (is_zero_reg(a))                v = '0;
    else if (exc_live && a == EXC_A)   v = bus.exc_data;
    else if (wb_live && bus.wb_addr == a) v = bus.wb_data;
    else if (pend)                     v = fdat;
    else                               v = storage_rd(a);
    return v;
  endfunction
`else
  function automatic logic [DATA_W-1:0] read_sel(input logic [ADDR_W-1:0] a,
                                                 input logic pend,
                                                 input logic [DATA_W-1:0] fdat);
    return storage_rd(a);
  endfunction
`endif

  logic rd_pend1, rd_pend2;
  logic read_sel_unused;

  always_comb begin
    rd_pend1 = !reset && lk_hit1 && !is_zero_reg(bus.read_register1);
    rd_pend2 = !reset && lk_hit2 && !is_zero_reg(bus.read_register2);
  end

  assign read_sel_unused  = ^{lk_dat1, lk_dat2};
  assign bus.read_data1   = read_sel(bus.read_register1, rd_pend1, lk_dat1);
  assign bus.read_data2   = read_sel(bus.read_register2, rd_pend2, lk_dat2);
  assign bus.rd_pending1  = rd_pend1;
  assign bus.rd_pending2  = rd_pend2;
  assign bus.wb_ready     = wb_rdy;
  assign bus.commit_valid = wr_en;
  assign bus.commit_addr  = wr_en ? wr_addr : '0;

endmodule

// File: tb/tb_reg_write_port.sv
// Directed vector bench for reg_write_port; expectations are hand-computed per cycle,
// with separate read-data columns for the storage-only and forwarding builds.
module tb_reg_write_port;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_write_port_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  reg_write_port dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        rst;
    logic        wv;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ev;
    logic [31:0] ed;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        rdy;
    logic        cv;
    logic [4:0]  ca;
    logic [31:0] d1;  // storage-only read port 1
    logic [31:0] b1;  // forwarding build read port 1
    logic [31:0] d2;
    logic [31:0] b2;
    logic        p1;
    logic        p2;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t tbl [24];

  function automatic vec_t mk(logic rst, logic wv, logic [4:0] wa, logic [31:0] wd,
                              logic ev, logic [31:0] ed, logic [4:0] r1, logic [4:0] r2,
                              logic rdy, logic cv, logic [4:0] ca,
                              logic [31:0] d1, logic [31:0] b1, logic [31:0] d2, logic [31:0] b2,
                              logic p1, logic p2);
    vec_t v;
    v.rst = rst; v.wv = wv; v.wa = wa; v.wd = wd; v.ev = ev; v.ed = ed; v.r1 = r1; v.r2 = r2;
    v.rdy = rdy; v.cv = cv; v.ca = ca; v.d1 = d1; v.b1 = b1; v.d2 = d2; v.b2 = b2;
    v.p1 = p1; v.p2 = p2;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset              = v.rst;
    bus.wb_valid       = v.wv;
    bus.wb_addr        = v.wa;
    bus.wb_data        = v.wd;
    bus.exc_valid      = v.ev;
    bus.exc_data       = v.ed;
    bus.read_register1 = v.r1;
    bus.read_register2 = v.r2;
  endtask

  initial begin
    //              rst wv wa  wd            ev ed         r1  r2  rdy cv ca  d1            b1            d2            b2            p1 p2
    tbl[0]  = mk(1, 1, 5,  32'h1,        1, 32'h9,    0,  0,  0, 0, 0,  32'h0,        32'h0,        32'h0,        32'h0,        0, 0);
    tbl[1]  = mk(1, 0, 0,  32'h0,        0, 32'h0,    5,  26, 0, 0, 0,  32'h0,        32'h0,        32'h0,        32'h0,        0, 0);
    tbl[2]  = mk(0, 1, 5,  32'hDEADBEEF, 0, 32'h0,    1,  0,  1, 1, 5,  32'h0,        32'h0,        32'h0,        32'h0,        0, 0);
    tbl[3]  = mk(0, 0, 0,  32'h0,        0, 32'h0,    5,  0,  1, 0, 0,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h0,        0, 0);
    tbl[4]  = mk(0, 1, 3,  32'h11,       1, 32'h400,  5,  4,  1, 1, 26, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h0,        0, 0);
    tbl[5]  = mk(0, 0, 0,  32'h0,        0, 32'h0,    3,  26, 1, 1, 3,  32'h0,        32'h11,       32'h400,      32'h400,      1, 0);
    tbl[6]  = mk(0, 0, 0,  32'h0,        0, 32'h0,    3,  0,  1, 0, 0,  32'h11,       32'h11,       32'h0,        32'h0,        0, 0);
    tbl[7]  = mk(0, 1, 10, 32'hA,        1, 32'h500,  10, 26, 1, 1, 26, 32'h0,        32'hA,        32'h400,      32'h500,      0, 0);
    tbl[8]  = mk(0, 1, 11, 32'hB,        1, 32'h501,  10, 11, 1, 1, 26, 32'h0,        32'hA,        32'h0,        32'hB,        1, 0);
    tbl[9]  = mk(0, 1, 12, 32'hC,        1, 32'h502,  11, 12, 0, 1, 26, 32'h0,        32'hB,        32'h0,        32'h0,        1, 0);
    tbl[10] = mk(0, 1, 12, 32'hC,        0, 32'h0,    26, 10, 0, 1, 10, 32'h502,      32'h502,      32'h0,        32'hA,        0, 1);
    tbl[11] = mk(0, 1, 12, 32'hC,        0, 32'h0,    10, 11, 1, 1, 11, 32'hA,        32'hA,        32'h0,        32'hB,        0, 1);
    tbl[12] = mk(0, 0, 0,  32'h0,        0, 32'h0,    11, 12, 1, 1, 12, 32'hB,        32'hB,        32'h0,        32'hC,        0, 1);
    tbl[13] = mk(0, 0, 0,  32'h0,        0, 32'h0,    12, 0,  1, 0, 0,  32'hC,        32'hC,        32'h0,        32'h0,        0, 0);
    tbl[14] = mk(0, 1, 3,  32'h33,       1, 32'h600,  0,  0,  1, 1, 26, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0);
    tbl[15] = mk(0, 1, 26, 32'h1,        0, 32'h0,    26, 3,  1, 1, 3,  32'h600,      32'h1,        32'h11,       32'h33,       0, 1);
    tbl[16] = mk(0, 0, 0,  32'h0,        1, 32'h2,    26, 3,  1, 1, 26, 32'h600,      32'h2,        32'h33,       32'h33,       1, 0);
    tbl[17] = mk(0, 0, 0,  32'h0,        0, 32'h0,    26, 0,  1, 0, 0,  32'h2,        32'h2,        32'h0,        32'h0,        0, 0);
    tbl[18] = mk(0, 0, 0,  32'h0,        0, 32'h0,    26, 5,  1, 0, 0,  32'h2,        32'h2,        32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
    tbl[19] = mk(0, 1, 0,  32'hFFFFFFFF, 0, 32'h0,    0,  5,  1, 0, 0,  32'h0,        32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
    tbl[20] = mk(0, 0, 0,  32'h0,        0, 32'h0,    0,  3,  1, 0, 0,  32'h0,        32'h0,        32'h33,       32'h33,       0, 0);
    tbl[21] = mk(0, 1, 20, 32'h20,       1, 32'h7,    0,  0,  1, 1, 26, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0);
    tbl[22] = mk(1, 0, 0,  32'h0,        0, 32'h0,    20, 26, 0, 0, 0,  32'h0,        32'h0,        32'h7,        32'h7,        0, 0);
    tbl[23] = mk(0, 0, 0,  32'h0,        0, 32'h0,    20, 26, 1, 0, 0,  32'h0,        32'h0,        32'h0,        32'h0,        0, 0);

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i]);
      @(negedge clk);
      check($sformatf("row%0d wb_ready", i),     32'(bus.wb_ready),     32'(tbl[i].rdy));
      check($sformatf("row%0d commit_valid", i), 32'(bus.commit_valid), 32'(tbl[i].cv));
      check($sformatf("row%0d commit_addr", i),  32'(bus.commit_addr),  32'(tbl[i].ca));
`ifdef REG_BYPASS_EN
      check($sformatf("row%0d read_data1", i),   bus.read_data1,        tbl[i].b1);
      check($sformatf("row%0d read_data2", i),   bus.read_data2,        tbl[i].b2);
`else
      check($sformatf("row%0d read_data1", i),   bus.read_data1,        tbl[i].d1);
      check($sformatf("row%0d read_data2", i),   bus.read_data2,        tbl[i].d2);
`endif
      check($sformatf("row%0d rd_pending1", i),  32'(bus.rd_pending1),  32'(tbl[i].p1));
      check($sformatf("row%0d rd_pending2", i),  32'(bus.rd_pending2),  32'(tbl[i].p2));
      @(posedge clk);
      #1;
    end

    // Cut-through write read back in the same cycle: forwarded or old value depending on build.
    reset              = 1'b0;
    bus.exc_valid      = 1'b0;
    bus.exc_data       = '0;
    bus.wb_valid       = 1'b1;
    bus.wb_addr        = 5'd7;
    bus.wb_data        = 32'hA5;
    bus.read_register1 = 5'd7;
    bus.read_register2 = 5'd0;
    @(negedge clk);
    check("cut commit_valid", 32'(bus.commit_valid), 32'h1);
    check("cut commit_addr",  32'(bus.commit_addr),  32'h7);
    check("cut rd_pending1",  32'(bus.rd_pending1),  32'h0);
`ifdef REG_BYPASS_EN
    check("cut same-cycle read", bus.read_data1, 32'hA5);
`else
    check("cut same-cycle read", bus.read_data1, 32'h0);
`endif
    @(posedge clk);
    #1;
    bus.wb_valid = 1'b0;
    @(negedge clk);
    check("cut next-cycle read", bus.read_data1, 32'hA5);
    check("cut idle commit",     32'(bus.commit_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
